regfile_access_arbiter: RTL
===========================

# regfile_access_arbiter

Two-port access arbiter and sequencer for the single-port N-bit M-wide register file. It accepts independent read/write requests from two requesters and grants the file to one at a time. It drives the file's address, write-data, write and read strobes, captures read data, and returns a one-cycle acknowledge to the winning requester. It sits between the register file and its two masters (control unit and host/debug port).

## Interface
Parameters:
- P_RegWidth, 8, number of registers in the file; address width AW = $clog2(P_RegWidth)
- P_BitWidth, 16, register data width

Ports:
- In_Clock_50MHz  input  1  system clock, rising-edge
- In_Reset_n  input  1  reset, asynchronous, active-low
- In_Req0 / In_Req1  input  1  access request from requester 0 / 1
- In_Write0 / In_Write1  input  1  1 = write, 0 = read (valid while Req high)
- In_Address0 / In_Address1  input  AW  target register
- In_WriteData0 / In_WriteData1  input  P_BitWidth  write data
- Out_Ack0 / Out_Ack1  output  1  one-cycle completion pulse
- Out_ReadData0 / Out_ReadData1  output  P_BitWidth  read result, held until the next read completes for that requester
- Out_RF_Address  output  AW  to register file address
- Out_RF_WriteData  output  P_BitWidth  to register file write data
- Out_RF_Write  output  1  register file write strobe
- Out_RF_Read  output  1  register file read strobe
- In_RF_ReadData  input  P_BitWidth  register file read data (combinational from address)
- Out_Busy  output  1  high in ACCESS and RESP

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if no Req, stay. Otherwise pick a winner, latch its Write, Address and WriteData into command registers, record the winner, and go to ACCESS.
- ACCESS: Out_RF_Address and Out_RF_WriteData come from the command registers. Exactly one of Out_RF_Write or Out_RF_Read is high for this single cycle. On a read, In_RF_ReadData is captured into the winner's Out_ReadData at the closing edge. Go to RESP.
- RESP: the winner's Out_Ack is high for one cycle. Go to IDLE.
- Requests are level-sensitive. A requester holds Req and its command stable until Ack. A Req still high in the cycle after Ack is a new request.
- The command is latched in IDLE, so input changes after the grant edge do not affect the transaction.
- The loser's Req is ignored until the next IDLE and is never lost while held.
- Out_RF_Address and Out_RF_WriteData hold their last value outside ACCESS. The strobes are 0 outside ACCESS.
- A write completion leaves Out_ReadDataN unchanged.
- Addresses ≥ P_RegWidth pass through unchecked.
- Reset values: state IDLE; all Out_Ack, Out_ReadData, Out_RF_* and Out_Busy are 0; priority pointer = requester 0.
- Reset mid-transaction: the async reset drops strobes immediately. The transaction is abandoned with no Ack and no write.

## Timing
- A Req sampled high in IDLE at edge k gives ACCESS in cycle k+1 and Ack in cycle k+2.
- Minimum 3 cycles per transaction.
- A continuously held Req completes once every 3 cycles.
- Back-to-back with both requesters active: 3 cycles per transaction, alternating under round-robin.
- Out_ReadDataN updates on the same edge that raises Out_AckN.

## Configuration
- REGFILE_ARB_ROUND_ROBIN_EN defined:
  - Round-robin arbitration. The last-granted requester has lowest priority on a simultaneous request; the pointer updates at each grant.
  - Reset pointer favours requester 0.
- Undefined:
  - Fixed priority, requester 0 always wins simultaneous requests.
  - Requester 1 can starve; the pointer logic is not built.

## Test plan
- Write then read: Req0 write 0x1234 to addr 3, then Req0 read addr 3 → Out_RF_Write one cycle with address 3, Ack0 at k+2; Out_ReadData0 = 0x1234 with the second Ack0.
- Simultaneous held requests, ROUND_ROBIN_EN defined: Req0 reads addr 1 and Req1 reads addr 2 for 12 cycles → Acks alternate 0,1,0,1; no request is dropped.
- Same stimulus, macro undefined → only Ack0 pulses, every 3 cycles; Ack1 never asserts.
- Command stability: change In_Address0 from 5 to 6 the cycle after grant → Out_RF_Address = 5 in ACCESS.
- Reset mid-op: assert In_Reset_n=0 during ACCESS of a write 0xBEEF to addr 4 → strobes drop asynchronously, no Ack; a subsequent read of addr 4 returns the prior value; all outputs are 0 during reset.
- Write completion: Out_ReadData1 holds 0x00AA from an earlier read; Req1 write 0x5555 → Ack1 pulses and Out_ReadData1 stays 0x00AA.

Source files
------------

// File: rtl/regfile_access_arbiter_if.sv
// Request/response and register-file bus between two masters,
// the access arbiter and the single-port register file.
interface regfile_access_arbiter_if #(
  parameter int P_RegWidth = 8,
  parameter int P_BitWidth = 16
);
  localparam int AW = (P_RegWidth > 1) ? $clog2(P_RegWidth) : 1;

  logic                  In_Req0;
  logic                  In_Req1;
  logic                  In_Write0;
  logic                  In_Write1;
  logic [AW-1:0]         In_Address0;
  logic [AW-1:0]         In_Address1;
  logic [P_BitWidth-1:0] In_WriteData0;
  logic [P_BitWidth-1:0] In_WriteData1;
  logic                  Out_Ack0;
  logic                  Out_Ack1;
  logic [P_BitWidth-1:0] Out_ReadData0;
  logic [P_BitWidth-1:0] Out_ReadData1;
  logic [AW-1:0]         Out_RF_Address;
  logic [P_BitWidth-1:0] Out_RF_WriteData;
  logic                  Out_RF_Write;
  logic                  Out_RF_Read;
  logic [P_BitWidth-1:0] In_RF_ReadData;
  logic                  Out_Busy;

  modport slave (
    input  In_Req0, In_Req1,
    input  In_Write0, In_Write1,
    input  In_Address0, In_Address1,
    input  In_WriteData0, In_WriteData1,
    input  In_RF_ReadData,
    output Out_Ack0, Out_Ack1,
    output Out_ReadData0, Out_ReadData1,
    output Out_RF_Address, Out_RF_WriteData,
    output Out_RF_Write, Out_RF_Read,
    output Out_Busy
  );

  modport master (
    output In_Req0, In_Req1,
    output In_Write0, In_Write1,
    output In_Address0, In_Address1,
    output In_WriteData0, In_WriteData1,
    output In_RF_ReadData,
    input  Out_Ack0, Out_Ack1,
    input  Out_ReadData0, Out_ReadData1,
    input  Out_RF_Address, Out_RF_WriteData,
    input  Out_RF_Write, Out_RF_Read,
    input  Out_Busy
  );
endinterface

// File: rtl/regfile_access_arbiter.sv
// Two-requester arbiter/sequencer for a single-port register file.
// Define REGFILE_ARB_ROUND_ROBIN_EN for round-robin, else fixed priority.
module regfile_access_arbiter #(
  parameter int P_RegWidth = 8,
  parameter int P_BitWidth = 16
) (
  input logic In_Clock_50MHz,
  input logic In_Reset_n,
  regfile_access_arbiter_if.slave bus
);
  localparam int AW = (P_RegWidth > 1) ? $clog2(P_RegWidth) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_e;

  state_e                state_q, state_d;
  logic                  win_q, win_d;
  logic                  wr_q, wr_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [P_BitWidth-1:0] wdata_q, wdata_d;
  logic [P_BitWidth-1:0] rdata0_q, rdata0_d;
  logic [P_BitWidth-1:0] rdata1_q, rdata1_d;
  logic                  any_req;
  logic                  pick;

  assign any_req = bus.In_Req0 | bus.In_Req1;

`ifdef REGFILE_ARB_ROUND_ROBIN_EN
  // prio_q names the requester that wins a tie
  logic prio_q, prio_d;

  always_comb begin
    pick = ~bus.In_Req0;
    if (bus.In_Req0 && bus.In_Req1) pick = prio_q;
  end

  always_comb begin
    prio_d = prio_q;
    if (state_q == S_IDLE && any_req) prio_d = ~pick;
  end

  always_ff @(posedge In_Clock_50MHz or negedge In_Reset_n) begin
    if (!In_Reset_n) prio_q <= 1'b0;
    else             prio_q <= prio_d;
  end
`else
  always_comb pick = ~bus.In_Req0;
`endif

  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    unique case (state_q)
      S_IDLE: begin
        if (any_req) begin
          state_d = S_ACCESS;
          win_d   = pick;
          wr_d    = pick ? bus.In_Write1 : bus.In_Write0;
          addr_d  = pick ? bus.In_Address1 : bus.In_Address0;
          wdata_d = pick ? bus.In_WriteData1
                         : bus.In_WriteData0;
        end
      end
      S_ACCESS: begin
        state_d = S_RESP;
        if (!wr_q) begin
          if (win_q) rdata1_d = bus.In_RF_ReadData;
          else       rdata0_d = bus.In_RF_ReadData;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge In_Clock_50MHz or negedge In_Reset_n) begin
    if (!In_Reset_n) begin
      state_q  <= S_IDLE;
      win_q    <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Strobes decode from state so async reset kills them at once
  assign bus.Out_RF_Write     = (state_q == S_ACCESS) & wr_q;
  assign bus.Out_RF_Read      = (state_q == S_ACCESS) & ~wr_q;
  assign bus.Out_RF_Address   = addr_q;
  assign bus.Out_RF_WriteData = wdata_q;
  assign bus.Out_Ack0         = (state_q == S_RESP) & ~win_q;
  assign bus.Out_Ack1         = (state_q == S_RESP) & win_q;
  assign bus.Out_ReadData0    = rdata0_q;
  assign bus.Out_ReadData1    = rdata1_q;
  assign bus.Out_Busy         = (state_q != S_IDLE);
endmodule
